hazard_ctrl: RTL

- Pipeline control unit that drives the WEN/flush inputs of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Acts as the producer side of the pipeline-register control protocol. It consumes hazard information extracted from the register outputs (ID/EX load destination, EX/MEM memory request and branch resolution, MEM/WB halt) plus cache hit signals.
- Sequences memory-wait freezes, load-use bubbles, taken-branch/jump squashes and the terminal halt.

---
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard/control unit. Produces the write enables and
//            flush (NOP) requests for the IF/ID, ID/EX, EX/MEM and MEM/WB
//            registers and the PC write enable. Sequences memory-wait
//            freezes, load-use bubbles, taken-branch/jump squashes and the
//            terminal halt.
// Ports    : CLK, RST (sync, active-high)
//            ihit, dhit                  - cache completion strobes
//            xmem_memreq, xmem_brtaken   - EX/MEM memory request / branch taken
//            idex_memread, idex_rt       - ID/EX load and its destination
//            ifid_rs, ifid_rt,
//            ifid_uses_rt, id_jump       - ID-stage operand / jump decode
//            mwb_halt                    - halt reached MEM/WB
//            pc_WEN, *_WEN, *_flush      - pipeline register controls (comb)
//            dmem_hold, halted           - registered status
//            stall_cnt, flush_cnt        - saturating performance counters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             xmem_memreq,
    input  logic             xmem_brtaken,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             id_jump,
    input  logic             mwb_halt,
    output logic             pc_WEN,
    output logic             ifid_WEN,
    output logic             idex_WEN,
    output logic             xmem_WEN,
    output logic             mwb_WEN,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             xmem_flush,
    output logic             mwb_flush,
    output logic             dmem_hold,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0]       S_RUN    = 1'b0;
    localparam logic [0:0]       S_HALTED = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic             r_dmem_done;
    logic             r_halted;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_run;
    logic w_mem_ok;
    logic w_advance;
    logic w_load_use;
    logic w_stall_evt;
    logic w_flush_evt;

    assign w_run    = (r_state == S_RUN);
    // A data access finished in an earlier frozen cycle still counts as done.
    assign w_mem_ok  = !xmem_memreq | dhit | r_dmem_done;
    assign w_advance = ihit & w_mem_ok & w_run;

    // r0 is hard-wired zero, so a load to r0 never creates a dependency.
    assign w_load_use = idex_memread & (idex_rt != 5'd0) &
                        ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

    // A taken branch squashes the dependent instruction, so no bubble is counted.
    assign w_stall_evt = !w_advance | (!xmem_brtaken & w_load_use);
    assign w_flush_evt = w_advance & xmem_brtaken;

    always_comb begin
        pc_WEN     = 1'b0;
        ifid_WEN   = 1'b0;
        idex_WEN   = 1'b0;
        xmem_WEN   = 1'b0;
        mwb_WEN    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        xmem_flush = 1'b0;
        mwb_flush  = 1'b0;
        if (RST) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            xmem_flush = 1'b1;
            mwb_flush  = 1'b1;
        end else if (w_advance) begin
            if (xmem_brtaken) begin
                pc_WEN     = 1'b1;
                ifid_WEN   = 1'b1;
                idex_WEN   = 1'b1;
                xmem_WEN   = 1'b1;
                mwb_WEN    = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                xmem_flush = 1'b1;
            end else if (w_load_use) begin
                // Hold PC and IF/ID; inject a bubble into ID/EX. A jump in
                // IF/ID stays there and is squashed on the next advance.
                idex_WEN   = 1'b1;
                idex_flush = 1'b1;
                xmem_WEN   = 1'b1;
                mwb_WEN    = 1'b1;
            end else begin
                pc_WEN     = 1'b1;
                ifid_WEN   = 1'b1;
                idex_WEN   = 1'b1;
                xmem_WEN   = 1'b1;
                mwb_WEN    = 1'b1;
                ifid_flush = id_jump;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_RUN;
            r_dmem_done <= 1'b0;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_run) begin
            if (mwb_halt) begin
                r_state  <= S_HALTED;
                r_halted <= 1'b1;
            end
            if (w_advance) begin
                r_dmem_done <= 1'b0;
            end else if (dhit) begin
                r_dmem_done <= 1'b1;
            end
            if (w_stall_evt && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_evt && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign dmem_hold = r_dmem_done;
    assign halted    = r_halted;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire
